mux4way16_arbiter: RTL

//  - Round-robin arbiter that shares one WIDTH-bit output bus among four requesters (a,b,c,d).
//  - Drives the 2-bit select of the 4-way 16-bit mux datapath and registers the selected word.
//  - Downstream side uses a valid/ready handshake. Requester side uses req/ack.
//  - Sits between four data producers (e.g. CPU, timer, keyboard, DMA) and one shared consumer.

---
 rtl/mux4way16_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mux4way16_arbiter.sv
// mux4way16_arbiter: round-robin 4:1 arbiter with a registered output word; define ARB_LOCK_EN for burst lock.
// Latency: 1 cycle from ack to dout_valid; accept and consume in the same cycle give back-to-back beats.
// Backpressure: dout_valid && !dout_ready stalls (ack=0, dout/sel/last frozen); requesters hold req until acked.
module mux4way16_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] din_c,
    input  logic [WIDTH-1:0] din_d,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1
`ifdef ARB_LOCK_EN
        , LOCKED = 2'd2
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       last;
    logic [1:0]       rr_win;
    logic             rr_found;
    logic [1:0]       rr_idx;
    logic [1:0]       winner;
    logic             hold;
    logic             can_take;
    logic             accept;
    logic [WIDTH-1:0] win_dat;

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [1:0]    owner;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);
    // The owner keeps the bus only while it still asks for it and still holds lock.
    assign hold    = (state == LOCKED) && req[owner] && lock[owner];
`else
    logic unused_cfg;

    assign unused_cfg = (^lock) ^ (MAX_BURST < 1);
    assign hold       = 1'b0;
`endif

    assign dout_valid = (state != EMPTY);
    assign busy       = dout_valid;
    assign can_take   = !dout_valid || dout_ready;

    // Scan starts one past the last grant and wraps 3->0.
    always_comb begin
        rr_win   = last;
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last + 2'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_win   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        winner = rr_win;
        accept = can_take && rr_found;
`ifdef ARB_LOCK_EN
        if (hold) begin
            winner = owner;
            accept = can_take;
        end
`endif
    end

    assign ack = (rst_n && accept) ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        win_dat = din_a;
        case (winner)
            2'd0:    win_dat = din_a;
            2'd1:    win_dat = din_b;
            2'd2:    win_dat = din_c;
            default: win_dat = din_d;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
`ifdef ARB_LOCK_EN
            if (hold) begin
                if (cnt_inc < CW'(MAX_BURST)) begin
                    state_nxt = LOCKED;
                end
            end else if (lock[winner] && (MAX_BURST > 1)) begin
                state_nxt = LOCKED;
            end
`endif
        end else if (dout_valid && dout_ready) begin
            state_nxt = EMPTY;
        end
`ifdef ARB_LOCK_EN
        else if ((state == LOCKED) && !hold) begin
            // Owner released during a stall: the word stays, the burst ends.
            state_nxt = FULL;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // last resets to 3 so the first scan after reset starts at source a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            sel  <= 2'b00;
            last <= 2'b11;
        end else if (accept) begin
            dout <= win_dat;
            sel  <= winner;
            last <= winner;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 2'b00;
            cnt   <= '0;
        end else if (accept) begin
            owner <= winner;
            cnt   <= hold ? cnt_inc : CW'(1);
        end
    end
`endif

endmodule
